batcharger_adc_sequencer: RTL

BATCHARGER_ADC_SEQUENCER -- requirements
Module: batcharger_adc_sequencer

---
 rtl/batcharger_pkg.sv | 45 ++++
 rtl/batcharger_adc_sequencer_if.sv | 31 +++
 rtl/batcharger_sar_core.sv | 49 ++++
 rtl/batcharger_adc_sequencer.sv | 123 ++++++++++++
 4 files changed

// File: rtl/batcharger_pkg.sv
// Shared types and constants for the battery-charger ADC sequencer.
// Channel helpers implement the V -> I -> T round-robin search.
package batcharger_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_CONV   = 2'd2,
        ST_STORE  = 2'd3
    } state_t;

    localparam logic [1:0] CH_V = 2'b00;
    localparam logic [1:0] CH_I = 2'b01;
    localparam logic [1:0] CH_T = 2'b10;

    localparam int SAMPLE_CYCLES = 2;
    localparam int ADC_BITS      = 8;

    function automatic logic [1:0] ch_inc(input logic [1:0] ch);
        return (ch == CH_T) ? CH_V : (ch + 2'd1);
    endfunction

    function automatic logic ch_enabled(input logic [1:0] ch, input logic [2:0] ens);
        case (ch)
            CH_V:    return ens[0];
            CH_I:    return ens[1];
            CH_T:    return ens[2];
            default: return 1'b0;
        endcase
    endfunction

    // Returns {found, channel}: first enabled channel at or after 'start'; ens = {t, i, v}.
    function automatic logic [2:0] ch_pick(input logic [1:0] start, input logic [2:0] ens);
        logic [1:0] c;
        logic [2:0] res;
        c   = start;
        res = 3'b000;
        for (int n = 0; n < 3; n++) begin
            if (!res[2] && ch_enabled(c, ens)) res = {1'b1, c};
            c = ch_inc(c);
        end
        return res;
    endfunction

endpackage

// File: rtl/batcharger_adc_sequencer_if.sv
// Controller-side bus of the ADC sequencer: channel enables, comparator in,
// mux/DAC/strobe out, conversion results and a debug view of the FSM state.
interface batcharger_adc_sequencer_if;
    import batcharger_pkg::*;

    logic                en;
    logic                vmonen;
    logic                imonen;
    logic                tmonen;
    logic                cmp;
    logic [1:0]          sel;
    logic                sample;
    logic [ADC_BITS-1:0] dac;
    logic [ADC_BITS-1:0] vbat;
    logic [ADC_BITS-1:0] ibat;
    logic [ADC_BITS-1:0] tbat;
    logic                vtok;
    logic                busy;
    state_t              dbg_state;

    modport master (
        output en, vmonen, imonen, tmonen, cmp,
        input  sel, sample, dac, vbat, ibat, tbat, vtok, busy, dbg_state
    );

    modport slave (
        input  en, vmonen, imonen, tmonen, cmp,
        output sel, sample, dac, vbat, ibat, tbat, vtok, busy, dbg_state
    );

endinterface

// File: rtl/batcharger_sar_core.sv
// Successive-approximation bit register: one bit decided per cycle, MSB first,
// starting the cycle after i_start; i_abort discards the partial code.
module batcharger_sar_core
    import batcharger_pkg::*;
(
    input  logic                clk,
    input  logic                rstz,
    input  logic                i_start,
    input  logic                i_abort,
    input  logic                i_cmp,
    output logic [ADC_BITS-1:0] o_dac,
    output logic                o_done,
    output logic [ADC_BITS-1:0] o_code
);

    localparam int BW = $clog2(ADC_BITS);

    logic                r_active;
    logic [BW-1:0]       r_bit;
    logic [ADC_BITS-1:0] r_code;
    logic [ADC_BITS-1:0] w_trial;

    assign w_trial = r_code | (ADC_BITS'(1) << r_bit);

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_active <= 1'b0;
            r_bit    <= '0;
            r_code   <= '0;
        end else if (i_abort) begin
            r_active <= 1'b0;
            r_bit    <= '0;
            r_code   <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_bit    <= BW'(ADC_BITS - 1);
            r_code   <= '0;
        end else if (r_active) begin
            if (i_cmp) r_code <= w_trial;
            if (r_bit == '0) r_active <= 1'b0;
            else             r_bit    <= r_bit - BW'(1);
        end
    end

    assign o_dac  = r_active ? w_trial : '0;
    assign o_done = r_active && (r_bit == '0);
    assign o_code = r_code;

endmodule

// File: rtl/batcharger_adc_sequencer.sv
// Round-robin V/I/T ADC sequencer: 2-cycle sample, 8-cycle SAR conversion,
// 1-cycle store, chaining straight into the next enabled channel.
module batcharger_adc_sequencer
    import batcharger_pkg::*;
(
    input  logic                           clk,
    input  logic                           rstz,
    inout  wire                            dvdd,
    inout  wire                            dgnd,
    batcharger_adc_sequencer_if.slave      bus
);

    localparam int SCW = $clog2(SAMPLE_CYCLES);

    state_t              r_state;
    state_t              w_next;
    logic [SCW-1:0]      r_scnt;
    logic [1:0]          r_sel;
    logic [1:0]          r_ptr;
    logic [ADC_BITS-1:0] r_vbat;
    logic [ADC_BITS-1:0] r_ibat;
    logic [ADC_BITS-1:0] r_tbat;
    logic                r_vtok;
    logic                r_vseen;
    logic                r_tseen;

    logic [1:0]          w_search;
    logic [2:0]          w_pick;
    logic                w_start;
    logic                w_sar_done;
    logic [ADC_BITS-1:0] w_sar_dac;
    logic [ADC_BITS-1:0] w_sar_code;
    logic                w_vseen_n;
    logic                w_tseen_n;
    wire                 w_unused_supply;

    // Supply pins carry no logic; this only keeps them referenced.
    assign w_unused_supply = dvdd ^ dgnd;

    // In STORE the search starts after the channel just converted.
    assign w_search  = (r_state == ST_STORE) ? ch_inc(r_sel) : r_ptr;
    assign w_pick    = ch_pick(w_search, {bus.tmonen, bus.imonen, bus.vmonen});
    assign w_start   = (r_state == ST_SAMPLE) && (r_scnt == SCW'(SAMPLE_CYCLES - 1));
    assign w_vseen_n = r_vseen | (r_sel == CH_V);
    assign w_tseen_n = r_tseen | (r_sel == CH_T);

    batcharger_sar_core u_sar (
        .clk     (clk),
        .rstz    (rstz),
        .i_start (w_start && bus.en),
        .i_abort (!bus.en),
        .i_cmp   (bus.cmp),
        .o_dac   (w_sar_dac),
        .o_done  (w_sar_done),
        .o_code  (w_sar_code)
    );

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (!bus.en) begin
            w_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (w_pick[2]) w_next = ST_SAMPLE;
                ST_SAMPLE: if (w_start) w_next = ST_CONV;
                ST_CONV:   if (w_sar_done) w_next = ST_STORE;
                ST_STORE:  w_next = w_pick[2] ? ST_SAMPLE : ST_IDLE;
                default:   w_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            r_scnt  <= '0;
            r_sel   <= CH_V;
            r_ptr   <= CH_V;
            r_vbat  <= '0;
            r_ibat  <= '0;
            r_tbat  <= '0;
            r_vtok  <= 1'b0;
            r_vseen <= 1'b0;
            r_tseen <= 1'b0;
        end else begin
            if (r_state == ST_SAMPLE && w_next == ST_SAMPLE) r_scnt <= r_scnt + SCW'(1);
            else                                              r_scnt <= '0;
            if (r_state != ST_SAMPLE && w_next == ST_SAMPLE) r_sel <= w_pick[1:0];
            // Dropping en forgets V/T history so vtok needs fresh results of both.
            if (!bus.en) begin
                r_vtok  <= 1'b0;
                r_vseen <= 1'b0;
                r_tseen <= 1'b0;
            end else if (r_state == ST_STORE) begin
                case (r_sel)
                    CH_V:    r_vbat <= w_sar_code;
                    CH_I:    r_ibat <= w_sar_code;
                    CH_T:    r_tbat <= w_sar_code;
                    default: ;
                endcase
                r_ptr   <= ch_inc(r_sel);
                r_vseen <= w_vseen_n;
                r_tseen <= w_tseen_n;
                r_vtok  <= r_vtok | (w_vseen_n & w_tseen_n);
            end
        end
    end

    assign bus.sel       = r_sel;
    assign bus.sample    = (r_state == ST_SAMPLE);
    assign bus.dac       = (r_state == ST_CONV) ? w_sar_dac : '0;
    assign bus.vbat      = r_vbat;
    assign bus.ibat      = r_ibat;
    assign bus.tbat      = r_tbat;
    assign bus.vtok      = r_vtok;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.dbg_state = r_state;

endmodule
